// File: rtl/i_cache.sv
// Direct-mapped, read-only instruction cache. Hits are served from a local
// line array; misses are filled with a single 256-bit line read from memory.
module i_cache #(
  parameter int S_INDEX = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic [31:0]      mem_address,
  output logic             mem_resp,
  output logic [31:0]      mem_rdata,
  input  logic             inval,
  output logic             pmem_read,
  output logic [31:0]      pmem_address,
  input  logic             pmem_resp,
  input  logic [255:0]     pmem_rdata,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int SETS  = 1 << S_INDEX;
  localparam int TAG_W = 27 - S_INDEX;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FILL  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  logic [31:0]        r_req_addr;
  logic [SETS-1:0]    r_valid;
  logic [TAG_W-1:0]   r_tag_mem [SETS];
  logic [255:0]       r_data_mem [SETS];
  logic [TAG_W-1:0]   r_rd_tag;
  logic [255:0]       r_rd_data;
  logic [31:0]        r_fill_word;
  logic [31:0]        r_rdata_hold;
  logic               r_pmem_read;
  logic [31:0]        r_pmem_addr;
  logic [CNT_W-1:0]   r_hit_cnt;
  logic [CNT_W-1:0]   r_miss_cnt;

  logic [S_INDEX-1:0] w_acc_idx;
  logic [S_INDEX-1:0] w_req_idx;
  logic [TAG_W-1:0]   w_req_tag;
  logic [2:0]         w_req_word;
  logic               w_hit;
  logic [31:0]        w_hit_word;
  logic [31:0]        w_line_word;
  logic               w_fill_we;
  logic [SETS-1:0]    w_fill_set;
  logic [SETS-1:0]    w_valid_next;
  logic               w_unused;

  // Address fields: live address indexes the array at accept; the latched
  // request address drives every compare and word select afterwards.
  assign w_acc_idx   = mem_address[4+S_INDEX:5];
  assign w_req_idx   = r_req_addr[4+S_INDEX:5];
  assign w_req_tag   = r_req_addr[31:5+S_INDEX];
  assign w_req_word  = r_req_addr[4:2];
  assign w_hit       = r_valid[w_req_idx] && (r_rd_tag == w_req_tag);
  assign w_hit_word  = r_rd_data[{w_req_word, 5'd0} +: 32];
  assign w_line_word = pmem_rdata[{w_req_word, 5'd0} +: 32];
  assign w_fill_we   = (r_state == ST_FILL) && pmem_resp;
  assign w_fill_set  = w_fill_we ? ({{(SETS-1){1'b0}}, 1'b1} << w_req_idx) : '0;
  assign w_unused    = &{1'b0, r_req_addr[1:0]};

  assign pmem_read    = r_pmem_read;
  assign pmem_address = r_pmem_addr;
  assign hit_count    = r_hit_cnt;
  assign miss_count   = r_miss_cnt;

  // Response decode from registered state: hit answers in CHECK, fill in RESP.
  always_comb begin
    mem_resp  = 1'b0;
    mem_rdata = r_rdata_hold;
    if ((r_state == ST_CHECK) && w_hit) begin
      mem_resp  = 1'b1;
      mem_rdata = w_hit_word;
    end else if (r_state == ST_RESP) begin
      mem_resp  = 1'b1;
      mem_rdata = r_fill_word;
    end else begin
      mem_resp  = 1'b0;
      mem_rdata = r_rdata_hold;
    end
  end

  // Next valid vector: inval wipes everything, a fill in the same edge survives.
  always_comb begin
    w_valid_next = (inval ? '0 : r_valid) | w_fill_set;
  end

  // Valid bits, reset to all-invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_valid_next;
    end
  end

  // Tag/data array: synchronous read at accept, line write on fill return.
  always_ff @(posedge clk) begin
    if ((r_state == ST_IDLE) && mem_read) begin
      r_rd_tag  <= r_tag_mem[w_acc_idx];
      r_rd_data <= r_data_mem[w_acc_idx];
    end
    if (w_fill_we) begin
      r_tag_mem[w_req_idx]  <= w_req_tag;
      r_data_mem[w_req_idx] <= pmem_rdata;
    end
  end

  // Last delivered word, so mem_rdata holds between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata_hold <= 32'd0;
    end else if (mem_resp) begin
      r_rdata_hold <= mem_rdata;
    end else begin
      r_rdata_hold <= r_rdata_hold;
    end
  end

  // Control FSM with memory request, fill capture and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_req_addr  <= 32'd0;
      r_fill_word <= 32'd0;
      r_pmem_read <= 1'b0;
      r_pmem_addr <= 32'd0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem_read) begin
            r_req_addr <= mem_address;
            r_state    <= ST_CHECK;
          end else begin
            r_state    <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (w_hit) begin
            if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            r_state <= ST_IDLE;
          end else begin
            if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            r_pmem_read <= 1'b1;
            r_pmem_addr <= {r_req_addr[31:5], 5'd0};
            r_state     <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (pmem_resp) begin
            r_pmem_read <= 1'b0;
            r_fill_word <= w_line_word;
            r_state     <= ST_RESP;
          end else begin
            r_state     <= ST_FILL;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_pmem_read <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
